board_eval: RTL and testbench
=============================

// Module: board_eval
// PURPOSE
//  Material evaluator sitting directly downstream of the piece move generators. Generators
//  write child boards (64 B each, contiguous) into SDRAM; the CPU then points this block
//  at that array. It reads every square, sums signed piece values per board and reports
//  the index and score of the best board for the side to move.
// PARAMETERS
//  MAX_BOARDS   64    max boards per job; NUM_BOARDS is clamped to this
//  KING_VALUE   20000 material value of a king (magnitude 6)
// PORTS
//  clk                   in   1   clock
//  rst_n                 in   1   synchronous active-low reset
//  slave_waitrequest     out  1   high whenever state is not IDLE, ACK_START or FINISH
//  slave_address         in   4   CPU register index
//  slave_read            in   1   CPU read strobe
//  slave_readdata        out  32  register readback
//  slave_write           in   1   CPU write strobe
//  slave_writedata       in   32  register write data
//  master_waitrequest    in   1   SDRAM stall
//  master_address        out  32  byte address, one square per address
//  master_read           out  1   read request, held until readdatavalid
//  master_readdata       in   32  [7:0] = signed piece code
//  master_readdatavalid  in   1   read data valid
//  master_write          out  1   write request (SCORE_WRITEBACK_EN only)
//  master_writedata      out  32  board score (SCORE_WRITEBACK_EN only)
// BEHAVIOUR
//  Registers: write 0 = start; 1 = BASE addr; 2 = NUM_BOARDS; 3 = MAXIMIZE (bit0);
//    4 = SCORE_BASE. Read 0 = best index; read 1 = best score.
//  Piece code: 0 empty, sign = colour (+white), |code| 1..6 = P,N,B,R,Q,K = 100,320,330,
//    500,900,KING_VALUE. |code| >6 counts 0. Score is signed 32 b: sum(white) - sum(black).
//  States: IDLE -> (write addr!=0) LOAD -> IDLE; IDLE -> (write addr0) ACK_START ->
//    CHECK_BOARD -> RD_SQ -> ACC_SQ -> (sq<63) RD_SQ | (sq==63) BOARD_DONE -> [WR_SCORE] ->
//    CHECK_BOARD. CHECK_BOARD goes to FINISH when board==NUM_BOARDS.
//    FINISH -> IDLE on slave_read of addr 0; FINISH holds result until then.
//  RD_SQ: master_read=1, address = BASE + board*64 + sq; leaves on readdatavalid only.
//  ACC_SQ: acc += value(readdata[7:0]). BOARD_DONE: compare acc with best, clear acc.
//  Compare: MAXIMIZE=1 takes acc > best, 0 takes acc < best; strict, so ties keep the
//    lowest index. best is initialised from board 0 (first board always taken).
//  NUM_BOARDS=0: straight to FINISH; index 32'hFFFFFFFF, score 32'h80000000.
//  NUM_BOARDS > MAX_BOARDS: only MAX_BOARDS are evaluated.
//  Reset values: every output 0 except master_address 32'hFFFFFFFF (idle value) and
//    slave_waitrequest 0 (state IDLE). Config registers reset to 0; index/score reset to
//    the empty values above.
//  Reset mid-job: abort immediately, no further master traffic, next cycle is IDLE.
//  Slave writes during a job are stalled by waitrequest, never dropped.
//  Latency per board is 64*(read latency+2)+1 cycles (+ write cycles when enabled).
// CONFIGURATION
//  SCORE_WRITEBACK_EN defined: WR_SCORE state after BOARD_DONE writes the board's acc to
//    SCORE_BASE + board*4 and holds while master_waitrequest is high.
//  SCORE_WRITEBACK_EN undefined: WR_SCORE is absent, master_write is tied 0, and
//    register 4 is ignored.
// STRUCTURE
//  chess_pkg: piece code constants (EMPTY, PAWN..KING), value constants, BOARD_BYTES=64,
//    and the state enum typedef.
//  One sub-module piece_value: combinational signed 8 b code -> signed 32 b value,
//    reused by later evaluators.
// TESTING
//  Start board: 16 pawns + all pieces, NUM=1 -> score 0, index 0.
//  3 boards: white queen up / rook up / even, MAXIMIZE=1 -> index 0, score 900.
//  Same 3 boards, MAXIMIZE=0 -> index 2, score 0.
//  Two boards both +500, MAXIMIZE=1 -> index 0 (tie keeps lowest).
//  NUM=0 -> FINISH at once; index FFFFFFFF, score 80000000; no master_read.
//  Random readdatavalid delay 0-7 plus rst_n pulse mid-board -> master_read drops the next
//    cycle; rerun gives the golden score.
//  SCORE_WRITEBACK_EN, 2 boards, SCORE_BASE=0x1000, waitrequest stalls -> 0x1000 and
//    0x1004 get the scores.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared chess constants for the evaluator family: piece codes, material values,
// board geometry and the board_eval state encoding.
package chess_pkg;

    localparam int unsigned BOARD_BYTES = 64;

    localparam logic signed [7:0] EMPTY  = 8'sd0;
    localparam logic signed [7:0] PAWN   = 8'sd1;
    localparam logic signed [7:0] KNIGHT = 8'sd2;
    localparam logic signed [7:0] BISHOP = 8'sd3;
    localparam logic signed [7:0] ROOK   = 8'sd4;
    localparam logic signed [7:0] QUEEN  = 8'sd5;
    localparam logic signed [7:0] KING   = 8'sd6;

    localparam int PAWN_VALUE         = 100;
    localparam int KNIGHT_VALUE       = 320;
    localparam int BISHOP_VALUE       = 330;
    localparam int ROOK_VALUE         = 500;
    localparam int QUEEN_VALUE        = 900;
    localparam int KING_VALUE_DEFAULT = 20000;

    // Result registers hold these until a job has evaluated at least one board
    localparam logic [31:0] EMPTY_INDEX = 32'hFFFF_FFFF;
    localparam logic [31:0] EMPTY_SCORE = 32'h8000_0000;

    localparam logic [3:0] ST_IDLE        = 4'd0;
    localparam logic [3:0] ST_LOAD        = 4'd1;
    localparam logic [3:0] ST_ACK_START   = 4'd2;
    localparam logic [3:0] ST_CHECK_BOARD = 4'd3;
    localparam logic [3:0] ST_RD_SQ       = 4'd4;
    localparam logic [3:0] ST_ACC_SQ      = 4'd5;
    localparam logic [3:0] ST_BOARD_DONE  = 4'd6;
    localparam logic [3:0] ST_WR_SCORE    = 4'd7;
    localparam logic [3:0] ST_FINISH      = 4'd8;

    typedef enum logic [3:0] {
        IDLE        = ST_IDLE,
        LOAD        = ST_LOAD,
        ACK_START   = ST_ACK_START,
        CHECK_BOARD = ST_CHECK_BOARD,
        RD_SQ       = ST_RD_SQ,
        ACC_SQ      = ST_ACC_SQ,
        BOARD_DONE  = ST_BOARD_DONE,
        WR_SCORE    = ST_WR_SCORE,
        FINISH      = ST_FINISH
    } state_t;

endpackage

// File: rtl/board_eval_if.sv
// CPU register port and SDRAM read/write port of board_eval, bundled as one interface.
// Modport slave is the evaluator's view; modport master is the system (CPU + SDRAM) view.
interface board_eval_if;

    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;

    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_write;
    logic [31:0] master_writedata;

    modport slave (
        output slave_waitrequest, slave_readdata,
        input  slave_address, slave_read, slave_write, slave_writedata,
        output master_address, master_read, master_write, master_writedata,
        input  master_waitrequest, master_readdata, master_readdatavalid
    );

    modport master (
        input  slave_waitrequest, slave_readdata,
        output slave_address, slave_read, slave_write, slave_writedata,
        input  master_address, master_read, master_write, master_writedata,
        output master_waitrequest, master_readdata, master_readdatavalid
    );

endinterface

// File: rtl/board_eval_piece_value.sv
// piece_value: signed 8-bit piece code to signed 32-bit material value.
// Sign carries colour (positive = white); magnitudes outside 1..6 are worth nothing.
module piece_value
    import chess_pkg::*;
#(
    parameter int KING_VALUE = KING_VALUE_DEFAULT
) (
    input  logic signed [7:0]  code,
    output logic signed [31:0] value
);

    logic [7:0]         mag;
    logic signed [31:0] base;

    always_comb begin
        // -128 has no positive counterpart; it stays 128 here and falls to the zero case
        mag = code[7] ? (~code + 8'd1) : code;
        case (mag)
            PAWN:    base = PAWN_VALUE;
            KNIGHT:  base = KNIGHT_VALUE;
            BISHOP:  base = BISHOP_VALUE;
            ROOK:    base = ROOK_VALUE;
            QUEEN:   base = QUEEN_VALUE;
            KING:    base = KING_VALUE;
            default: base = '0;
        endcase
        value = code[7] ? -base : base;
    end

endmodule

// File: rtl/board_eval.sv
// board_eval: sums material over an SDRAM array of 64-byte boards and reports the best one.
// Build option SCORE_WRITEBACK_EN adds a per-board score write to SCORE_BASE + board*4.
module board_eval
    import chess_pkg::*;
#(
    parameter int unsigned MAX_BOARDS = 64,
    parameter int          KING_VALUE = KING_VALUE_DEFAULT
) (
    input logic         clk,
    input logic         rst_n,
    board_eval_if.slave bus
);

    state_t             state;
    logic [31:0]        base_addr;
    logic [31:0]        num_boards;
    logic               maximize;
    logic [31:0]        board;
    logic [5:0]         sq;
    logic signed [7:0]  sq_code;
    logic signed [31:0] sq_value;
    logic signed [31:0] acc;
    logic [31:0]        best_idx;
    logic signed [31:0] best_score;
    logic [31:0]        board_limit;
    logic               take;
`ifdef SCORE_WRITEBACK_EN
    logic [31:0]        score_base;
    logic signed [31:0] wr_score;
`endif

    piece_value #(.KING_VALUE(KING_VALUE)) u_piece_value (
        .code  (sq_code),
        .value (sq_value)
    );

    always_comb begin
        board_limit = (num_boards > 32'(MAX_BOARDS)) ? 32'(MAX_BOARDS) : num_boards;
        // Strict compare keeps the lowest index on ties; board 0 always seeds the best
        take = (board == '0) || (maximize ? (acc > best_score) : (acc < best_score));
    end

    assign bus.slave_waitrequest = !(state inside {IDLE, ACK_START, FINISH});

    always_comb begin
        bus.slave_readdata = '0;
        if (bus.slave_read) begin
            case (bus.slave_address)
                4'd0:    bus.slave_readdata = best_idx;
                4'd1:    bus.slave_readdata = best_score;
                default: bus.slave_readdata = '0;
            endcase
        end
    end

    always_comb begin
        bus.master_read      = (state == RD_SQ);
        bus.master_address   = '1;
        bus.master_write     = 1'b0;
        bus.master_writedata = '0;
        if (state == RD_SQ)
            bus.master_address = base_addr + board * BOARD_BYTES + 32'(sq);
`ifdef SCORE_WRITEBACK_EN
        if (state == WR_SCORE) begin
            bus.master_address   = score_base + (board << 2);
            bus.master_write     = 1'b1;
            bus.master_writedata = wr_score;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            base_addr  <= '0;
            num_boards <= '0;
            maximize   <= 1'b0;
            board      <= '0;
            sq         <= '0;
            sq_code    <= '0;
            acc        <= '0;
            best_idx   <= EMPTY_INDEX;
            best_score <= EMPTY_SCORE;
`ifdef SCORE_WRITEBACK_EN
            score_base <= '0;
            wr_score   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.slave_write) begin
                        if (bus.slave_address == 4'd0) begin
                            state <= ACK_START;
                        end else begin
                            state <= LOAD;
                            case (bus.slave_address)
                                4'd1: base_addr  <= bus.slave_writedata;
                                4'd2: num_boards <= bus.slave_writedata;
                                4'd3: maximize   <= bus.slave_writedata[0];
`ifdef SCORE_WRITEBACK_EN
                                4'd4: score_base <= bus.slave_writedata;
`endif
                                default: ;
                            endcase
                        end
                    end
                end
                LOAD: state <= IDLE;
                ACK_START: begin
                    board      <= '0;
                    sq         <= '0;
                    acc        <= '0;
                    best_idx   <= EMPTY_INDEX;
                    best_score <= EMPTY_SCORE;
                    state      <= CHECK_BOARD;
                end
                CHECK_BOARD: state <= (board == board_limit) ? FINISH : RD_SQ;
                RD_SQ: begin
                    if (bus.master_readdatavalid) begin
                        sq_code <= bus.master_readdata[7:0];
                        state   <= ACC_SQ;
                    end
                end
                ACC_SQ: begin
                    acc   <= acc + sq_value;
                    sq    <= sq + 6'd1;
                    state <= (sq == 6'd63) ? BOARD_DONE : RD_SQ;
                end
                BOARD_DONE: begin
                    if (take) begin
                        best_idx   <= board;
                        best_score <= acc;
                    end
                    acc <= '0;
`ifdef SCORE_WRITEBACK_EN
                    // board advances only after the score write so WR_SCORE can address it
                    wr_score <= acc;
                    state    <= WR_SCORE;
`else
                    board <= board + 32'd1;
                    state <= CHECK_BOARD;
`endif
                end
`ifdef SCORE_WRITEBACK_EN
                WR_SCORE: begin
                    if (!bus.master_waitrequest) begin
                        board <= board + 32'd1;
                        state <= CHECK_BOARD;
                    end
                end
`endif
                FINISH: begin
                    if (bus.slave_read && bus.slave_address == 4'd0)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_eval.sv
// Directed bench for board_eval: SDRAM/CPU models, a material model of the boards in
// memory, and a per-cycle checker of the master read address stream.
module tb_board_eval;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    board_eval_if bus();

    board_eval #(.MAX_BOARDS(64), .KING_VALUE(20000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    logic signed [7:0] mem [int unsigned];
    logic [31:0]       wmem [int unsigned];
    logic [31:0]       exp_addr_q [$];
    bit                rand_lat = 1'b0;
    bit                stall_wr = 1'b0;
    int                last_busy;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic signed [7:0] rd_mem(input int unsigned a);
        return mem.exists(a) ? mem[a] : 8'sd0;
    endfunction

    function automatic int piece_val(input logic signed [7:0] c);
        int m;
        int v;
        m = (c < 0) ? -int'(c) : int'(c);
        case (m)
            1: v = 100;
            2: v = 320;
            3: v = 330;
            4: v = 500;
            5: v = 900;
            6: v = 20000;
            default: v = 0;
        endcase
        return (c < 0) ? -v : v;
    endfunction

    function automatic int board_score(input int unsigned base, input int unsigned b);
        int s = 0;
        for (int unsigned q = 0; q < 64; q++) s += piece_val(rd_mem(base + b * 64 + q));
        return s;
    endfunction

    task automatic model_best(input int unsigned base, input int unsigned num, input bit mx,
                              output logic [31:0] idx, output logic [31:0] sc);
        int unsigned n;
        int best;
        int s;
        n = (num > 64) ? 64 : num;
        idx = 32'hFFFF_FFFF;
        sc = 32'h8000_0000;
        best = 0;
        for (int unsigned b = 0; b < n; b++) begin
            s = board_score(base, b);
            if (b == 0 || (mx ? (s > best) : (s < best))) begin
                best = s;
                idx = b;
                sc = s;
            end
        end
    endtask

    task automatic put_start(input int unsigned base, input int unsigned b);
        int back [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
        int unsigned a;
        a = base + b * 64;
        for (int unsigned q = 0; q < 64; q++) mem[a + q] = 8'sd0;
        for (int unsigned f = 0; f < 8; f++) begin
            mem[a + f]      = 8'(back[f]);
            mem[a + 8 + f]  = 8'sd1;
            mem[a + 48 + f] = -8'sd1;
            mem[a + 56 + f] = 8'(-back[f]);
        end
    endtask

    // ---------------- SDRAM responder ----------------
    initial begin
        bit in_req = 1'b0;
        int cnt = 0;
        int dly = 0;
        bus.master_readdatavalid = 1'b0;
        bus.master_readdata = '0;
        bus.master_waitrequest = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.master_read) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    cnt = 0;
                    dly = rand_lat ? int'($urandom_range(0, 7)) : 0;
                end else begin
                    cnt++;
                end
                bus.master_readdatavalid = (cnt == dly);
                bus.master_readdata = {24'($urandom()), rd_mem(bus.master_address)};
            end else begin
                in_req = 1'b0;
                bus.master_readdatavalid = 1'b0;
                bus.master_readdata = '0;
            end
            if (bus.master_write) begin
                bus.master_waitrequest = stall_wr ? ($urandom_range(0, 2) != 0) : 1'b0;
                if (!bus.master_waitrequest) wmem[bus.master_address] = bus.master_writedata;
            end else begin
                bus.master_waitrequest = 1'b0;
            end
        end
    end

    // ---------------- per-cycle read stream checker ----------------
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n) begin
                if (bus.master_read) begin
                    if (exp_addr_q.size() == 0) begin
                        check("no_read_expected", {31'b0, bus.master_read}, 32'd0);
                    end else begin
                        check("read_addr", bus.master_address, exp_addr_q[0]);
                        if (bus.master_readdatavalid) void'(exp_addr_q.pop_front());
                    end
                end
`ifndef SCORE_WRITEBACK_EN
                check("master_write_tied", {31'b0, bus.master_write}, 32'd0);
`endif
            end
        end
    end

    // ---------------- CPU tasks ----------------
    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        bus.slave_address = a;
        bus.slave_writedata = d;
        bus.slave_write = 1'b1;
        #4;
        while (bus.slave_waitrequest && n < 30000) begin
            @(negedge clk);
            #4;
            n++;
        end
        if (n >= 30000) check("write_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        bus.slave_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
        int n = 0;
        @(negedge clk);
        bus.slave_address = a;
        bus.slave_read = 1'b1;
        #4;
        while (bus.slave_waitrequest && n < 30000) begin
            @(negedge clk);
            #4;
            n++;
        end
        if (n >= 30000) check("read_timeout", 32'(n), 32'd0);
        d = bus.slave_readdata;
        @(posedge clk);
        #1;
        bus.slave_read = 1'b0;
    endtask

    task automatic start_job(input int unsigned base, input int unsigned num, input bit mx,
                             input int unsigned sb);
        int unsigned n;
        n = (num > 64) ? 64 : num;
        exp_addr_q.delete();
        for (int unsigned b = 0; b < n; b++)
            for (int unsigned q = 0; q < 64; q++) exp_addr_q.push_back(base + b * 64 + q);
        cpu_write(4'd1, base);
        cpu_write(4'd2, num);
        cpu_write(4'd3, {31'b0, mx});
`ifdef SCORE_WRITEBACK_EN
        cpu_write(4'd4, sb);
`else
        if (sb != 0) cpu_write(4'd4, sb);
`endif
        cpu_write(4'd0, 32'd0);
    endtask

    task automatic run_job(input string name, input int unsigned base, input int unsigned num,
                           input bit mx, input int unsigned sb,
                           input logic [31:0] lit_idx, input logic [31:0] lit_score);
        logic [31:0] m_idx, m_sc, d_idx, d_sc;
        int busy = 0;
        bit started = 1'b0;
        int k;
        start_job(base, num, mx, sb);
        for (k = 0; k < 30000; k++) begin
            @(negedge clk);
            #4;
            if (bus.slave_waitrequest) begin
                busy++;
                started = 1'b1;
            end else if (started) begin
                break;
            end
        end
        if (k >= 30000) check({name, "_timeout"}, 32'(k), 32'd0);
        last_busy = busy;
        model_best(base, num, mx, m_idx, m_sc);
        cpu_read(4'd1, d_sc);
        cpu_read(4'd0, d_idx);
        check({name, "_idx"}, d_idx, m_idx);
        check({name, "_score"}, d_sc, m_sc);
        check({name, "_idx_lit"}, d_idx, lit_idx);
        check({name, "_score_lit"}, d_sc, lit_score);
        check({name, "_reads_left"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int k;
        bus.slave_address = '0;
        bus.slave_read = 1'b0;
        bus.slave_write = 1'b0;
        bus.slave_writedata = '0;

        // reset state
        repeat (3) @(negedge clk);
        #4;
        check("rst_waitrequest", {31'b0, bus.slave_waitrequest}, 32'd0);
        check("rst_readdata", bus.slave_readdata, 32'd0);
        check("rst_master_read", {31'b0, bus.master_read}, 32'd0);
        check("rst_master_addr", bus.master_address, 32'hFFFF_FFFF);
        check("rst_master_write", {31'b0, bus.master_write}, 32'd0);
        check("rst_master_wdata", bus.master_writedata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // start position, one board, zero-latency SDRAM: 64*(0+2)+1 plus two CHECK_BOARD visits
        put_start(32'h0, 0);
        run_job("start", 32'h0, 1, 1'b1, 0, 32'd0, 32'd0);
`ifdef SCORE_WRITEBACK_EN
        check("busy_cycles", 32'(last_busy), 32'(64 * (0 + 2) + 1 + 2 + 1));
`else
        check("busy_cycles", 32'(last_busy), 32'(64 * (0 + 2) + 1 + 2));
`endif

        // queen up / rook up / even
        put_start(32'h100, 0); mem[32'h100 + 59] = 8'sd0;
        put_start(32'h100, 1); mem[32'h140 + 56] = 8'sd0;
        put_start(32'h100, 2);
        check("model_queen_up", 32'(board_score(32'h100, 0)), 32'd900);
        check("model_rook_up", 32'(board_score(32'h100, 1)), 32'd500);
        run_job("max3", 32'h100, 3, 1'b1, 0, 32'd0, 32'd900);
        run_job("min3", 32'h100, 3, 1'b0, 0, 32'd2, 32'd0);

        // tie keeps lowest index
        put_start(32'h800, 0); mem[32'h800 + 63] = 8'sd0;
        put_start(32'h800, 1); mem[32'h840 + 56] = 8'sd0;
        run_job("tie", 32'h800, 2, 1'b1, 0, 32'd0, 32'd500);

        // no boards
        run_job("zero", 32'h100, 0, 1'b1, 0, 32'hFFFF_FFFF, 32'h8000_0000);
        check("zero_busy", 32'(last_busy), 32'd1);

        // out-of-range and extreme codes: 7,-7,127,-128 count 0; K - p = 19900
        for (int unsigned q = 0; q < 64; q++) mem[32'h2000 + q] = 8'sd0;
        mem[32'h2000] = 8'sd7;
        mem[32'h2001] = -8'sd7;
        mem[32'h2002] = 8'sd127;
        mem[32'h2003] = -8'sd128;
        mem[32'h2004] = 8'sd6;
        mem[32'h2005] = -8'sd1;
        check("model_odd_codes", 32'(board_score(32'h2000, 0)), 32'd19900);
        run_job("odd_codes", 32'h2000, 1, 1'b0, 0, 32'd0, 32'd19900);

        // NUM=65 is clamped; board 64 (queen up) must never be read
        for (int unsigned b = 0; b < 65; b++) put_start(32'h4000, b);
        mem[32'h4000 + 64 * 64 + 59] = 8'sd0;
        run_job("clamp", 32'h4000, 65, 1'b1, 0, 32'd0, 32'd0);

        // reset pulse mid-board with random read latency
        rand_lat = 1'b1;
        start_job(32'h100, 3, 1'b1, 0);
        repeat (150) @(negedge clk);
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.master_read) break;
        end
        check("rst_mid_read_seen", {31'b0, bus.master_read}, 32'd1);
        rst_n = 1'b0;
        exp_addr_q.delete();
        @(posedge clk);
        #1;
        check("rst_mid_read_drop", {31'b0, bus.master_read}, 32'd0);
        check("rst_mid_wait", {31'b0, bus.slave_waitrequest}, 32'd0);
        check("rst_mid_addr", bus.master_address, 32'hFFFF_FFFF);
        @(negedge clk);
        rst_n = 1'b1;
        cpu_read(4'd1, d);
        check("rst_mid_score", d, 32'h8000_0000);
        cpu_read(4'd0, d);
        check("rst_mid_idx", d, 32'hFFFF_FFFF);
        run_job("rerun", 32'h100, 3, 1'b1, 0, 32'd0, 32'd900);
        rand_lat = 1'b0;

`ifdef SCORE_WRITEBACK_EN
        stall_wr = 1'b1;
        wmem.delete();
        run_job("wb", 32'h100, 2, 1'b1, 32'h1000, 32'd0, 32'd900);
        check("wb_1000", wmem.exists(32'h1000) ? wmem[32'h1000] : 32'hDEAD_BEEF, 32'd900);
        check("wb_1004", wmem.exists(32'h1004) ? wmem[32'h1004] : 32'hDEAD_BEEF, 32'd500);
        stall_wr = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
